// File: rtl/alu_share_arb.sv
// Round-robin arbiter that time-shares one external combinational ALU between two
// requesters and registers the result, giving every operation a one-cycle latency.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_left,
  output logic [WIDTH-1:0] alu_right,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q, state_d;
  logic             own_q, own_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_zero_q, resp_zero_d;

  logic             free;
  logic             gnt_valid;
  logic             gnt_port;
  logic             grant_ok;

  // The held response slot frees up in the same cycle its handshake completes,
  // so a new request can be issued back-to-back.
  assign free     = (state_q == IDLE) | (resp_valid[own_q] & resp_ready[own_q]);
  assign grant_ok = free & gnt_valid & ~rst;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    case (req_valid)
      2'b01:   begin gnt_valid = 1'b1; gnt_port = 1'b0;          end
      2'b10:   begin gnt_valid = 1'b1; gnt_port = 1'b1;          end
      2'b11:   begin gnt_valid = 1'b1; gnt_port = ~last_grant_q; end
      default: begin gnt_valid = 1'b0; gnt_port = 1'b0;          end
    endcase
  end

  always_comb begin
    alu_op    = req_op0;
    alu_left  = req_a0;
    alu_right = req_b0;
    if (gnt_port) begin
      alu_op    = req_op1;
      alu_left  = req_a1;
      alu_right = req_b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi]  = grant_ok & (gnt_port == 1'(gi));
    assign resp_valid[gi] = (state_q == HOLD) & (own_q == 1'(gi));
  end

  always_comb begin
    state_d       = state_q;
    own_d         = own_q;
    last_grant_d  = last_grant_q;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    if (grant_ok) begin
      // An accept wins over a simultaneous handshake: the slot simply reloads.
      state_d       = HOLD;
      own_d         = gnt_port;
      last_grant_d  = gnt_port;
      resp_result_d = alu_result;
      resp_zero_d   = alu_zero;
    end else if ((state_q == HOLD) && resp_ready[own_q]) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      own_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      own_q         <= own_d;
      last_grant_q  <= last_grant_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  assign resp_result = resp_result_q;
  assign resp_zero   = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small behavioural ALU attached to its ALU port.
module tb_alu_share_arb;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [3:0]       req_op0, req_op1;
  logic [WIDTH-1:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_left, alu_right, alu_result;
  logic             alu_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Reference ALU: add, sub, sltu, and; anything else xors.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_left + alu_right;
      4'b0001: alu_result = alu_left - alu_right;
      4'b0110: alu_result = {{(WIDTH-1){1'b0}}, (alu_left < alu_right)};
      4'b1110: alu_result = alu_left & alu_right;
      default: alu_result = alu_left ^ alu_right;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic wait_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    resp_ready = 2'b00;
    req_op0 = 4'b0000; req_a0 = 0; req_b0 = 0;
    req_op1 = 4'b0000; req_a1 = 0; req_b1 = 0;

    // Reset
    wait_cycle();
    #1 check("rst_req_ready", 64'(req_ready), 64'(2'b00));
    wait_cycle();
    check("rst_resp_valid", 64'(resp_valid), 64'(2'b00));
    check("rst_result", 64'(resp_result), 64'd0);
    check("rst_zero", 64'(resp_zero), 64'd0);
    rst = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b11;

    // Single op on port 0
    req_valid = 2'b01; req_op0 = 4'b0000; req_a0 = 5; req_b0 = 7;
    #1 check("single_req_ready", 64'(req_ready), 64'(2'b01));
    wait_cycle();
    check("single_resp_valid", 64'(resp_valid), 64'(2'b01));
    check("single_result", 64'(resp_result), 64'd12);
    check("single_zero", 64'(resp_zero), 64'd0);

    // Zero flag on port 1, issued back-to-back with the port 0 handshake
    req_valid = 2'b10; req_op1 = 4'b0001; req_a1 = 32'h1234; req_b1 = 32'h1234;
    #1 check("zero_req_ready", 64'(req_ready), 64'(2'b10));
    wait_cycle();
    check("zero_resp_valid", 64'(resp_valid), 64'(2'b10));
    check("zero_result", 64'(resp_result), 64'd0);
    check("zero_flag", 64'(resp_zero), 64'd1);

    // Round robin: both valid for 4 cycles
    req_valid = 2'b11;
    req_op0 = 4'b1110; req_a0 = 32'hF0F0_F0F0; req_b0 = 32'hFF00_FF00;
    req_op1 = 4'b0110; req_a1 = 1; req_b1 = 2;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rr_req_ready_%0d", k), 64'(req_ready),
               (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      wait_cycle();
      check($sformatf("rr_resp_valid_%0d", k), 64'(resp_valid),
            (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      check($sformatf("rr_result_%0d", k), 64'(resp_result),
            (k % 2 == 0) ? 64'h0000_0000_F000_F000 : 64'd1);
    end

    // Backpressure: port 0 holds a response while port 1 waits
    req_valid = 2'b01; req_op0 = 4'b0000; req_a0 = 100; req_b0 = 23;
    #1 check("bp_issue_ready", 64'(req_ready), 64'(2'b01));
    wait_cycle();
    check("bp_resp_valid", 64'(resp_valid), 64'(2'b01));
    resp_ready = 2'b10;
    req_valid = 2'b10; req_op1 = 4'b0000; req_a1 = 3; req_b1 = 4;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("bp_req_ready_%0d", k), 64'(req_ready), 64'(2'b00));
      check($sformatf("bp_result_%0d", k), 64'(resp_result), 64'd123);
      check($sformatf("bp_valid_%0d", k), 64'(resp_valid), 64'(2'b01));
      wait_cycle();
    end
    resp_ready = 2'b11;
    #1 check("bp_release_ready", 64'(req_ready), 64'(2'b10));
    wait_cycle();
    check("bp_p1_valid", 64'(resp_valid), 64'(2'b10));
    check("bp_p1_result", 64'(resp_result), 64'd7);

    // Reset while port 0 holds a response
    req_valid = 2'b01; req_op0 = 4'b0000; req_a0 = 5; req_b0 = 7;
    wait_cycle();
    check("mid_hold_valid", 64'(resp_valid), 64'(2'b01));
    req_valid = 2'b00; resp_ready = 2'b00; rst = 1'b1;
    wait_cycle();
    rst = 1'b0;
    check("mid_rst_valid", 64'(resp_valid), 64'(2'b00));
    check("mid_rst_result", 64'(resp_result), 64'd0);
    check("mid_rst_zero", 64'(resp_zero), 64'd0);
    resp_ready = 2'b11;
    req_valid = 2'b11;
    req_op0 = 4'b0000; req_a0 = 5; req_b0 = 7;
    req_op1 = 4'b0001; req_a1 = 32'h1234; req_b1 = 32'h1234;
    #1 check("post_rst_grant", 64'(req_ready), 64'(2'b01));
    wait_cycle();
    check("post_rst_valid", 64'(resp_valid), 64'(2'b01));
    check("post_rst_result", 64'(resp_result), 64'd12);

    // Drain to idle
    req_valid = 2'b00;
    wait_cycle();
    check("idle_valid", 64'(resp_valid), 64'(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
